sc_counter_down_reload: RTL and testbench
=========================================

# sc_counter_down_reload

Loadable down-counter with optional auto-reload and a terminal-count strobe. It is the countdown counterpart of the alien-index up-counter. Game control blocks use it to pace periodic events (alien march steps, shot cooldown, bomb drop interval): a value is loaded, the block decrements on each enabled cycle, and it reports reaching zero. It sits between the game FSM, which loads it and supplies the count enable from a tick source, and any logic that consumes its terminal strobe.

## Interface
- COUNTER_DATAWIDTH_BUS, 5, width of count, load data and reload registers.
- SC_COUNTER_CLOCK_50  in  1  system clock; all state changes on its rising edge.
- SC_COUNTER_RESET_InLow  in  1  asynchronous, active-low reset.
- SC_COUNTER_load_InLow  in  1  low: load SC_COUNTER_data_InBus into the count and reload registers.
- SC_COUNTER_data_InBus  in  COUNTER_DATAWIDTH_BUS  load value, unsigned.
- SC_COUNTER_count_InLow  in  1  low: decrement enable for this cycle.
- SC_COUNTER_autoreload_InLow  in  1  low: on terminal count, reload instead of stopping.
- SC_COUNTER_regcount_OutBus  out  COUNTER_DATAWIDTH_BUS  current count register.
- SC_COUNTER_tick_OutLow  out  1  registered one-cycle low pulse on terminal count.
- SC_COUNTER_eoc_OutLow  out  1  low while in state DONE.
- SC_COUNTER_busy_OutLow  out  1  low while in state RUN.

## Operation
- Registers: count register (W bits), reload register (W bits), 2-bit state {IDLE, RUN, DONE}, tick register.
- Reset (asynchronous, SC_COUNTER_RESET_InLow=0): count=0, reload=0, state=IDLE, tick=1. Outputs at reset: regcount=0, tick=1, eoc=1, busy=1.
- Priority each edge, highest first: reset, load, decrement.
- Load (load_InLow=0, any state): count<=data, reload<=data, tick<=1. If data≠0, next state is RUN. If data=0, next state is DONE, with no tick.
- IDLE: count_InLow is ignored. The block leaves IDLE only on load.
- RUN, count_InLow=1: hold.
- RUN, count_InLow=0, count>1: count<=count-1.
- RUN, count_InLow=0, count=1 (terminal):
  - tick<=0.
  - If autoreload_InLow=0 and reload≠0: count<=reload and the state stays RUN. The period equals the reload value in enabled cycles.
  - Otherwise: count<=0, state<=DONE.
- DONE: count stays at 0 and count_InLow is ignored. The counter never underflows to all-ones. It leaves DONE only on load.
- autoreload_InLow is sampled only at the terminal edge. Changing it mid-run has no other effect.
- The tick register returns to 1 on every edge that is not a terminal decrement.
- Load in the same cycle as a terminal decrement: load wins, count=data, no tick.
- Arithmetic: unsigned, W bits. A decrement from 1 or more never wraps. Maximum load 2^W-1 (31 at default) gives 31 enabled cycles to terminal.

## Timing
- Latency load→regcount: 1 edge. busy/eoc reflect the new state in the same cycle as the new count.
- tick_OutLow goes low in the cycle immediately after the terminal edge, which is the same cycle regcount shows 0 or the reloaded value. It lasts exactly one clock.
- eoc_OutLow and busy_OutLow are decoded directly from the state register. They are glitch-free relative to the clock and mutually exclusive. Both are 1 in IDLE.
- With count_InLow held low after loading N (N≥1), the terminal edge is the Nth edge after the load edge.
- Reset asserted mid-operation forces the reset values immediately, without waiting for a clock. After release the block is IDLE with count 0.

## Test plan
- Reset: assert RESET_InLow=0 asynchronously mid-cycle → regcount=0, tick=1, eoc=1, busy=1 before the next edge. Toggling count_InLow in IDLE keeps regcount=0.
- One-shot: load 3, then count_InLow=0 continuously → regcount 3,2,1,0. tick=0 for only the cycle where regcount first reads 0. eoc goes to 0 and busy goes to 1 in that cycle. Five more enabled cycles keep regcount=0 (no wrap to 31).
- Auto-reload with pause: autoreload_InLow=0, load 2, count low continuously → regcount 2,1,2,1,2; tick low each time regcount returns to 2; busy stays 0. Then count_InLow=1 for 3 cycles → regcount holds and no tick.
- Load zero and full: load 0 → eoc=0 next cycle, busy=1, no tick. Load 31, count low continuously → tick after exactly 31 enabled cycles.
- Simultaneous: RUN with regcount=1, load_InLow=0 with data=5 and count_InLow=0 on the same edge → regcount=5, tick stays 1, busy=0.
- Reset mid-run: load 4, decrement to 2, assert reset between edges → regcount=0, busy=1 immediately. After release, count pulses have no effect until a load.

Source files
------------

// File: rtl/sc_counter_down_reload.sv
`default_nettype none
// ============================================================================
// Module   : sc_counter_down_reload
// Purpose  : Loadable down-counter with optional auto-reload and an active-low
//            one-cycle terminal-count strobe. Paces periodic game events
//            (march steps, shot cooldown, bomb interval).
// Ports    : SC_COUNTER_CLOCK_50          - system clock, rising edge
//            SC_COUNTER_RESET_InLow       - asynchronous active-low reset
//            SC_COUNTER_load_InLow        - low: load data into count+reload
//            SC_COUNTER_data_InBus        - unsigned load value
//            SC_COUNTER_count_InLow       - low: decrement enable this cycle
//            SC_COUNTER_autoreload_InLow  - low: reload on terminal count
//            SC_COUNTER_regcount_OutBus   - current count register
//            SC_COUNTER_tick_OutLow       - registered 1-cycle low terminal pulse
//            SC_COUNTER_eoc_OutLow        - low while DONE
//            SC_COUNTER_busy_OutLow       - low while RUN
// Revision : 1.0 - initial release
// ============================================================================
module sc_counter_down_reload #(
  parameter int COUNTER_DATAWIDTH_BUS = 5
) (
  input  logic                             SC_COUNTER_CLOCK_50,
  input  logic                             SC_COUNTER_RESET_InLow,
  input  logic                             SC_COUNTER_load_InLow,
  input  logic [COUNTER_DATAWIDTH_BUS-1:0] SC_COUNTER_data_InBus,
  input  logic                             SC_COUNTER_count_InLow,
  input  logic                             SC_COUNTER_autoreload_InLow,
  output logic [COUNTER_DATAWIDTH_BUS-1:0] SC_COUNTER_regcount_OutBus,
  output logic                             SC_COUNTER_tick_OutLow,
  output logic                             SC_COUNTER_eoc_OutLow,
  output logic                             SC_COUNTER_busy_OutLow
);

  localparam logic [COUNTER_DATAWIDTH_BUS-1:0] c_ZERO = '0;
  localparam logic [COUNTER_DATAWIDTH_BUS-1:0] c_ONE  = COUNTER_DATAWIDTH_BUS'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                           r_state;
  logic [COUNTER_DATAWIDTH_BUS-1:0] r_count;
  logic [COUNTER_DATAWIDTH_BUS-1:0] r_reload;
  logic                             r_tick;

  always_ff @(posedge SC_COUNTER_CLOCK_50 or negedge SC_COUNTER_RESET_InLow) begin
    if (!SC_COUNTER_RESET_InLow) begin
      r_state  <= ST_IDLE;
      r_count  <= c_ZERO;
      r_reload <= c_ZERO;
      r_tick   <= 1'b1;
    end else begin
      // The strobe is only ever low for the cycle after a terminal decrement.
      r_tick <= 1'b1;
      if (!SC_COUNTER_load_InLow) begin
        // Load outranks any decrement on the same edge, so no tick here.
        r_count  <= SC_COUNTER_data_InBus;
        r_reload <= SC_COUNTER_data_InBus;
        r_state  <= (SC_COUNTER_data_InBus != c_ZERO) ? ST_RUN : ST_DONE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_RUN: begin
            if (!SC_COUNTER_count_InLow) begin
              if (r_count > c_ONE) begin
                r_count <= r_count - c_ONE;
              end else if (r_count == c_ONE) begin
                r_tick <= 1'b0;
                // Reload mode is only consulted here, at the terminal edge.
                if (!SC_COUNTER_autoreload_InLow && (r_reload != c_ZERO)) begin
                  r_count <= r_reload;
                end else begin
                  r_count <= c_ZERO;
                  r_state <= ST_DONE;
                end
              end else begin
                // Zero while running cannot arise from a load; park safely
                // rather than wrapping to all-ones.
                r_count <= c_ZERO;
                r_state <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            r_count <= c_ZERO;
          end
          default: begin
            r_state <= ST_IDLE;
            r_count <= c_ZERO;
          end
        endcase
      end
    end
  end

  assign SC_COUNTER_regcount_OutBus = r_count;
  assign SC_COUNTER_tick_OutLow     = r_tick;
  // Pure state decodes; both high in IDLE, never both low.
  assign SC_COUNTER_eoc_OutLow      = (r_state != ST_DONE);
  assign SC_COUNTER_busy_OutLow     = (r_state != ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_sc_counter_down_reload.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_counter_down_reload
// Purpose  : Directed-vector bench for sc_counter_down_reload. Each stimulus
//            step queues its hand-computed expected outputs; a monitor pops
//            and compares them one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_counter_down_reload;

  localparam int c_W = 5;

  logic           clk;
  logic           rst_n;
  logic           i_load_n;
  logic [c_W-1:0] i_data;
  logic           i_count_n;
  logic           i_ar_n;
  logic [c_W-1:0] o_count;
  logic           o_tick_n;
  logic           o_eoc_n;
  logic           o_busy_n;

  typedef struct {
    logic [c_W-1:0] cnt;
    logic           tick;
    logic           eoc;
    logic           busy;
    string          tag;
  } exp_t;

  exp_t sb[$];
  int   n_total;
  int   n_pass;

  sc_counter_down_reload #(.COUNTER_DATAWIDTH_BUS(c_W)) u_dut (
    .SC_COUNTER_CLOCK_50        (clk),
    .SC_COUNTER_RESET_InLow     (rst_n),
    .SC_COUNTER_load_InLow      (i_load_n),
    .SC_COUNTER_data_InBus      (i_data),
    .SC_COUNTER_count_InLow     (i_count_n),
    .SC_COUNTER_autoreload_InLow(i_ar_n),
    .SC_COUNTER_regcount_OutBus (o_count),
    .SC_COUNTER_tick_OutLow     (o_tick_n),
    .SC_COUNTER_eoc_OutLow      (o_eoc_n),
    .SC_COUNTER_busy_OutLow     (o_busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input exp_t e);
    n_total++;
    if (o_count === e.cnt && o_tick_n === e.tick && o_eoc_n === e.eoc && o_busy_n === e.busy) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got cnt=%0d tick=%b eoc=%b busy=%b, expected cnt=%0d tick=%b eoc=%b busy=%b",
               e.tag, o_count, o_tick_n, o_eoc_n, o_busy_n, e.cnt, e.tick, e.eoc, e.busy);
    end
  endtask

  // Monitor: the DUT presents a new output every cycle, just after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      check(sb.pop_front());
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic ld, input logic [c_W-1:0] d, input logic cn, input logic ar,
                      input logic [c_W-1:0] ec, input logic et, input logic ee, input logic eb,
                      input string tag);
    exp_t e;
    @(negedge clk);
    i_load_n  = ld;
    i_data    = d;
    i_count_n = cn;
    i_ar_n    = ar;
    e.cnt = ec; e.tick = et; e.eoc = ee; e.busy = eb; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic direct(input logic [c_W-1:0] ec, input logic et, input logic ee,
                        input logic eb, input string tag);
    exp_t e;
    e.cnt = ec; e.tick = et; e.eoc = ee; e.busy = eb; e.tag = tag;
    check(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total   = 0;
    n_pass    = 0;
    rst_n     = 1'b1;
    i_load_n  = 1'b1;
    i_data    = '0;
    i_count_n = 1'b1;
    i_ar_n    = 1'b1;

    // Asynchronous reset mid-cycle, checked before any edge.
    #2 rst_n = 1'b0;
    #1 direct(5'd0, 1'b1, 1'b1, 1'b1, "reset_async");
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE ignores count enable.
    step(1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1, "idle_cnt0");
    step(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1, "idle_cnt1");
    step(1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1, "idle_cnt0b");

    // One-shot from 3.
    step(1'b0, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, "os_load3");
    step(1'b1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, "os_2");
    step(1'b1, 5'd0, 1'b0, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0, "os_1");
    step(1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, "os_term");
    for (int i = 0; i < 5; i++)
      step(1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, "os_nowrap");

    // Auto-reload period 2, then pause, then one-shot termination.
    step(1'b0, 5'd2, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, "ar_load2");
    step(1'b1, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, "ar_1a");
    step(1'b1, 5'd0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b1, 1'b0, "ar_reload_a");
    step(1'b1, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, "ar_1b");
    step(1'b1, 5'd0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b1, 1'b0, "ar_reload_b");
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, "ar_pause");
    step(1'b1, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, "ar_1c");
    step(1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, "ar_off_term");

    // Load zero goes straight to DONE without a tick.
    step(1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, "load0");
    step(1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, "load0_hold");

    // Full-scale load: terminal after exactly 31 enabled cycles.
    step(1'b0, 5'd31, 1'b0, 1'b1, 5'd31, 1'b1, 1'b1, 1'b0, "load31");
    for (int i = 1; i <= 30; i++)
      step(1'b1, 5'd0, 1'b0, 1'b1, 5'(31 - i), 1'b1, 1'b1, 1'b0, "full_dec");
    step(1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, "full_term");

    // Load coinciding with a terminal decrement: load wins, no tick.
    step(1'b0, 5'd2, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, "sim_load2");
    step(1'b1, 5'd0, 1'b0, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0, "sim_1");
    step(1'b0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, "sim_load5");

    // Reset mid-run.
    step(1'b0, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, "rr_load4");
    step(1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, "rr_3");
    step(1'b1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, "rr_2");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 direct(5'd0, 1'b1, 1'b1, 1'b1, "reset_midrun");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1, "post_rst_a");
    step(1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1, "post_rst_b");

    // Reload value 1: every enabled cycle is terminal.
    step(1'b0, 5'd1, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, "p1_load1");
    step(1'b1, 5'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, "p1_term_a");
    step(1'b1, 5'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, "p1_term_b");
    step(1'b1, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, "p1_hold");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
